// File: rtl/rom_stream_reader_if.sv
// ROM read port plus output word stream of the boot-ROM reader.
// master = reader side, slave = ROM / stream consumer side.
interface rom_stream_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic                  rom_ce;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_dout;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output rom_ce, rom_addr, m_valid, m_data, m_last,
    input  rom_dout, m_ready
  );

  modport slave (
    input  rom_ce, rom_addr, m_valid, m_data, m_last,
    output rom_dout, m_ready
  );
endinterface

// File: rtl/rom_stream_reader.sv
// Sequential reader for a 1-cycle-latency ROM feeding a valid/ready stream through a 2-entry buffer.
// start -> first beat in 3 cycles, 1 word/cycle when ready; reads throttle so buffer + in-flight never exceed 2.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  rom_stream_reader_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_ptr;
  logic [ADDR_WIDTH:0]   issue_rem;
  logic [ADDR_WIDTH:0]   out_rem;
  logic                  inflight;

  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;

  logic                  fifo_vld;
  logic                  pop;
  logic [2:0]            occ_next;
  logic                  issue;

  assign fifo_vld = (fifo_count != 2'd0);
  assign pop      = fifo_vld & bus.m_ready;

  // Occupancy the buffer would have after this cycle's pop, counting the word still in the ROM.
  assign occ_next = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue    = (state == READ) && (issue_rem != '0) && (occ_next < 3'd2);

  assign bus.rom_ce   = issue;
  assign bus.rom_addr = addr_ptr;
  assign bus.m_valid  = fifo_vld;
  assign bus.m_data   = buf_mem[rd_ptr];
  assign bus.m_last   = fifo_vld && (out_rem == CNT_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_ptr  <= '0;
      issue_rem <= '0;
      out_rem   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop) begin
        out_rem <= out_rem - CNT_ONE;
      end
      if (issue) begin
        addr_ptr  <= addr_ptr + ADDR_ONE;
        issue_rem <= issue_rem - CNT_ONE;
      end
      case (state)
        IDLE: begin
          if (start) begin
            addr_ptr  <= base_addr;
            issue_rem <= word_count;
            out_rem   <= word_count;
            busy      <= 1'b1;
            // An empty transfer idles one cycle in DRAIN so done lands two cycles after start.
            state     <= (word_count == '0) ? DRAIN : READ;
          end
        end
        READ: begin
          if (issue && (issue_rem == CNT_ONE)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((out_rem == '0) || (pop && (out_rem == CNT_ONE))) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      inflight   <= 1'b0;
    end else if (abort) begin
      // Clearing inflight drops the word the ROM returns next cycle.
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      inflight   <= 1'b0;
    end else begin
      inflight <= issue;
      if (inflight) begin
        buf_mem[wr_ptr] <= bus.rom_dout;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule
